// File: rtl/tlb_assoc.sv
// tlb_assoc - fully-associative TLB for the MIPS memory stage.
//
// Translates a virtual address to a physical address with a registered
// (one-cycle) lookup. Entries are filled lowest-invalid-first; once full,
// a round-robin pointer selects the victim. Writing a VPN that is already
// present updates that entry in place, so duplicate valid VPNs never exist
// and the match vector is always one-hot or zero.
//
// Optional feature: define TLB_ASID_EN to tag every entry with an ASID and
// require {asid, VPN} to match. Without it the asid port is absent.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   read       in   lookup request for vaddr
//   write      in   install mapping vaddr VPN -> paddr_new PPN
//   flush      in   invalidate all entries (wins over write)
//   vaddr      in   [VADDR_WIDTH-1:0] address for read/write
//   paddr_new  in   [PADDR_WIDTH-1:0] new physical address (PPN bits used)
//   asid       in   [ASID_WIDTH-1:0] address-space id (TLB_ASID_EN only)
//   paddr      out  [PADDR_WIDTH-1:0] {PPN, offset} of last hitting lookup
//   hit        out  last lookup hit
//   rd_valid   out  hit/paddr belong to a read issued last cycle
//   occupancy  out  number of valid entries
module tlb_assoc #(
    parameter int VADDR_WIDTH = 32,
    parameter int PADDR_WIDTH = 20,
    parameter int PAGE_BITS   = 12,
    parameter int ENTRIES     = 8,
    parameter int ASID_WIDTH  = 6
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           read,
    input  logic                           write,
    input  logic                           flush,
    input  logic [VADDR_WIDTH-1:0]         vaddr,
    input  logic [PADDR_WIDTH-1:0]         paddr_new,
`ifdef TLB_ASID_EN
    input  logic [ASID_WIDTH-1:0]          asid,
`endif
    output logic [PADDR_WIDTH-1:0]         paddr,
    output logic                           hit,
    output logic                           rd_valid,
    output logic [$clog2(ENTRIES+1)-1:0]   occupancy
);

    localparam int VPN_W = VADDR_WIDTH - PAGE_BITS;
    localparam int PPN_W = PADDR_WIDTH - PAGE_BITS;
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int OCC_W = $clog2(ENTRIES + 1);

    logic [ENTRIES-1:0] valid;
    logic [VPN_W-1:0]   vpn_tag [ENTRIES];
    logic [PPN_W-1:0]   ppn_tag [ENTRIES];
`ifdef TLB_ASID_EN
    logic [ASID_WIDTH-1:0] asid_tag [ENTRIES];
`else
    // Offset bits of paddr_new and the ASID width have no role in this build.
    logic [ASID_WIDTH-1:0] unused_asid;
    assign unused_asid = '0;
`endif
    logic               unused_offset;
    assign unused_offset = ^paddr_new[PAGE_BITS-1:0];

    logic [IDX_W-1:0]   rr_ptr;
    logic [VPN_W-1:0]   vpn;
    logic [ENTRIES-1:0] match;
    logic               any_match;
    logic               full;
    logic [IDX_W-1:0]   match_idx;
    logic [IDX_W-1:0]   free_idx;
    logic [IDX_W-1:0]   tgt_idx;
    logic [PPN_W-1:0]   match_ppn;
    logic               do_write;

    assign vpn = vaddr[VADDR_WIDTH-1:PAGE_BITS];

    always_comb begin
        match = '0;
        for (int i = 0; i < ENTRIES; i++) begin
`ifdef TLB_ASID_EN
            match[i] = valid[i] && (vpn_tag[i] == vpn) && (asid_tag[i] == asid);
`else
            match[i] = valid[i] && (vpn_tag[i] == vpn);
`endif
        end
    end

    assign any_match = |match;
    assign full      = &valid;

    // Match is one-hot, so OR-ing the selected PPNs yields the hitting PPN.
    // The free-slot search runs high-to-low so the lowest invalid index wins.
    always_comb begin
        match_idx = '0;
        match_ppn = '0;
        free_idx  = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (match[i]) begin
                match_idx = IDX_W'(i);
                match_ppn = match_ppn | ppn_tag[i];
            end
        end
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                free_idx = IDX_W'(i);
            end
        end
    end

    assign tgt_idx  = any_match ? match_idx : (full ? rr_ptr : free_idx);
    assign do_write = write && !flush;

    // ---- lookup/control register stage ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid     <= '0;
            occupancy <= '0;
            rr_ptr    <= '0;
            hit       <= 1'b0;
            rd_valid  <= 1'b0;
            paddr     <= '0;
        end else begin
            rd_valid <= read;
            if (read) begin
                hit <= any_match;
                if (any_match) begin
                    paddr <= {match_ppn, vaddr[PAGE_BITS-1:0]};
                end
            end

            if (flush) begin
                valid     <= '0;
                occupancy <= '0;
                rr_ptr    <= '0;
            end else if (write) begin
                valid[tgt_idx] <= 1'b1;
                if (!any_match) begin
                    if (full) begin
                        rr_ptr <= rr_ptr + IDX_W'(1);
                    end else begin
                        occupancy <= occupancy + OCC_W'(1);
                    end
                end
            end
        end
    end

    // ---- entry storage (data only, gated by valid) ----
    always_ff @(posedge clk) begin
        if (do_write) begin
            vpn_tag[tgt_idx]  <= vpn;
            ppn_tag[tgt_idx]  <= paddr_new[PADDR_WIDTH-1:PAGE_BITS];
`ifdef TLB_ASID_EN
            asid_tag[tgt_idx] <= asid;
`endif
        end
    end

endmodule

// File: tb/tb_tlb_assoc.sv
module tb_tlb_assoc;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        read;
    logic        write;
    logic        flush;
    logic [31:0] vaddr;
    logic [19:0] paddr_new;
`ifdef TLB_ASID_EN
    logic [5:0]  asid;
`endif
    logic [19:0] paddr;
    logic        hit;
    logic        rd_valid;
    logic [3:0]  occupancy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic        hit;
        logic [19:0] pa;
    } exp_t;

    exp_t        sb[$];
    logic [19:0] model_pa;

    tlb_assoc dut (
        .clk       (clk),
        .reset     (reset),
        .read      (read),
        .write     (write),
        .flush     (flush),
        .vaddr     (vaddr),
        .paddr_new (paddr_new),
`ifdef TLB_ASID_EN
        .asid      (asid),
`endif
        .paddr     (paddr),
        .hit       (hit),
        .rd_valid  (rd_valid),
        .occupancy (occupancy)
    );

    // Scoreboard consumer: every rd_valid pulse retires one expected lookup.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rd_valid === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL lookup_unexpected: got rd_valid=1, expected no outstanding read");
            end else begin
                e = sb.pop_front();
                if (hit !== e.hit || paddr !== e.pa) begin
                    n_fail++;
                    $display("FAIL lookup: got hit=%0b paddr=%h, expected hit=%0b paddr=%h",
                             hit, paddr, e.hit, e.pa);
                end
            end
        end
    end

    function automatic logic [31:0] mkva(input logic [19:0] v, input logic [11:0] off);
        return {v, off};
    endfunction

    function automatic logic [19:0] mkpa(input logic [7:0] p, input logic [11:0] off);
        return {p, off};
    endfunction

    // One cycle of stimulus, driven after the falling edge.
    task automatic op_cycle(input logic rd, input logic wr, input logic fl,
                            input logic [31:0] va, input logic [19:0] pa,
                            input logic eh, input logic [19:0] epa);
        exp_t e;
        @(negedge clk);
        read      = rd;
        write     = wr;
        flush     = fl;
        vaddr     = va;
        paddr_new = pa;
        if (rd) begin
            if (eh) model_pa = epa;
            e.hit = eh;
            e.pa  = model_pa;
            sb.push_back(e);
        end
    endtask

    task automatic op_read(input logic [31:0] va, input logic eh, input logic [19:0] epa);
        op_cycle(1'b1, 1'b0, 1'b0, va, 20'h0, eh, epa);
    endtask

    task automatic op_write(input logic [31:0] va, input logic [19:0] pa);
        op_cycle(1'b0, 1'b1, 1'b0, va, pa, 1'b0, 20'h0);
    endtask

    task automatic idle();
        @(negedge clk);
        read  = 1'b0;
        write = 1'b0;
        flush = 1'b0;
    endtask

    task automatic test_reset();
        read = 1'b0; write = 1'b0; flush = 1'b0;
        vaddr = '0; paddr_new = '0;
`ifdef TLB_ASID_EN
        asid = '0;
`endif
        reset = 1'b1;
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (hit !== 1'b0) begin n_fail++; $display("FAIL reset_hit: got %0b, expected 0", hit); end
        n_checks++;
        if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %0b, expected 0", rd_valid); end
        n_checks++;
        if (paddr !== 20'h0) begin n_fail++; $display("FAIL reset_paddr: got %h, expected 00000", paddr); end
        n_checks++;
        if (occupancy !== 4'd0) begin n_fail++; $display("FAIL reset_occupancy: got %0d, expected 0", occupancy); end
        @(negedge clk);
        reset    = 1'b1;
        model_pa = 20'h0;
        op_read(32'h00001014, 1'b0, 20'h0);
        idle();
        n_checks++;
        if (occupancy !== 4'd0) begin n_fail++; $display("FAIL empty_occupancy: got %0d, expected 0", occupancy); end
        @(posedge clk);
        #1;
        n_checks++;
        if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rd_valid_drop: got %0b, expected 0", rd_valid); end
    endtask

    task automatic test_basic();
        op_write(32'h00001012, 20'hf1012);
        op_read(32'h00001012, 1'b1, 20'hf1012);
        op_read(32'h00002123, 1'b0, 20'h0);
        idle();
        n_checks++;
        if (occupancy !== 4'd1) begin n_fail++; $display("FAIL basic_occupancy: got %0d, expected 1", occupancy); end
        @(posedge clk);
        #1;
        n_checks++;
        if (paddr !== 20'hf1012) begin n_fail++; $display("FAIL miss_holds_paddr: got %h, expected f1012", paddr); end
    endtask

    task automatic test_update();
        op_write(32'h00001000, 20'hf1000);
        op_write(32'h00001000, 20'ha7fff);
        op_read(32'h00001abc, 1'b1, 20'ha7abc);
        idle();
        n_checks++;
        if (occupancy !== 4'd1) begin n_fail++; $display("FAIL update_occupancy: got %0d, expected 1", occupancy); end
    endtask

    task automatic test_replace();
        for (int v = 1; v <= 8; v++) begin
            op_write(mkva(20'(v), 12'h000), mkpa(8'(v + 16), 12'h5a5));
        end
        idle();
        n_checks++;
        if (occupancy !== 4'd8) begin n_fail++; $display("FAIL full_occupancy: got %0d, expected 8", occupancy); end
        op_write(mkva(20'd9, 12'h000), mkpa(8'h99, 12'h000));
        op_read(32'h00001000, 1'b0, 20'h0);
        op_read(32'h00009004, 1'b1, 20'h99004);
        op_write(mkva(20'd10, 12'h000), mkpa(8'h1a, 12'h000));
        op_read(mkva(20'd2, 12'h777), 1'b0, 20'h0);
        op_read(mkva(20'd3, 12'h3c3), 1'b1, mkpa(8'h13, 12'h3c3));
        op_read(mkva(20'd10, 12'hfed), 1'b1, mkpa(8'h1a, 12'hfed));
        idle();
        n_checks++;
        if (occupancy !== 4'd8) begin n_fail++; $display("FAIL replace_occupancy: got %0d, expected 8", occupancy); end
    endtask

    task automatic test_back_to_back();
        // Read and write of VPN 11 on the same edge: lookup sees old contents.
        op_cycle(1'b1, 1'b1, 1'b0, mkva(20'd11, 12'h123), mkpa(8'h1b, 12'h000), 1'b0, 20'h0);
        op_read(mkva(20'd11, 12'h123), 1'b1, mkpa(8'h1b, 12'h123));
        idle();
    endtask

    task automatic test_flush();
        op_cycle(1'b1, 1'b0, 1'b1, mkva(20'd11, 12'h456), 20'h0, 1'b1, mkpa(8'h1b, 12'h456));
        idle();
        n_checks++;
        if (occupancy !== 4'd0) begin n_fail++; $display("FAIL flush_occupancy: got %0d, expected 0", occupancy); end
        @(posedge clk);
        #1;
        n_checks++;
        if (hit !== 1'b1 || paddr !== 20'h1b456) begin
            n_fail++;
            $display("FAIL flush_holds_out: got hit=%0b paddr=%h, expected hit=1 paddr=1b456", hit, paddr);
        end
        op_write(mkva(20'd4, 12'h000), mkpa(8'h44, 12'h000));
        op_cycle(1'b0, 1'b1, 1'b1, mkva(20'd3, 12'h000), mkpa(8'h33, 12'h000), 1'b0, 20'h0);
        idle();
        n_checks++;
        if (occupancy !== 4'd0) begin n_fail++; $display("FAIL flush_write_occupancy: got %0d, expected 0", occupancy); end
        for (int v = 3; v <= 11; v++) begin
            op_read(mkva(20'(v), 12'h010), 1'b0, 20'h0);
        end
        // Round-robin pointer restarts at 0 after a flush.
        for (int v = 32; v <= 39; v++) begin
            op_write(mkva(20'(v), 12'h000), mkpa(8'(v), 12'h000));
        end
        op_write(mkva(20'd40, 12'h000), mkpa(8'd40, 12'h000));
        op_read(mkva(20'd32, 12'h001), 1'b0, 20'h0);
        op_read(mkva(20'd35, 12'h002), 1'b1, mkpa(8'd35, 12'h002));
        op_read(mkva(20'd40, 12'h003), 1'b1, mkpa(8'd40, 12'h003));
        idle();
    endtask

    task automatic test_async_reset();
        op_read(mkva(20'd33, 12'habc), 1'b1, mkpa(8'd33, 12'habc));
        @(negedge clk);
        read  = 1'b1;
        vaddr = mkva(20'd33, 12'h000);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (rd_valid !== 1'b0 || hit !== 1'b0) begin
            n_fail++;
            $display("FAIL midread_reset: got rd_valid=%0b hit=%0b, expected 0 0", rd_valid, hit);
        end
        n_checks++;
        if (occupancy !== 4'd0) begin n_fail++; $display("FAIL midread_reset_occ: got %0d, expected 0", occupancy); end
        @(negedge clk);
        read     = 1'b0;
        reset    = 1'b1;
        model_pa = 20'h0;
        op_read(mkva(20'd33, 12'h000), 1'b0, 20'h0);
        idle();
    endtask

`ifdef TLB_ASID_EN
    task automatic test_asid();
        asid = 6'd1;
        op_write(mkva(20'd5, 12'h000), mkpa(8'h55, 12'h000));
        asid = 6'd2;
        op_read(mkva(20'd5, 12'h100), 1'b0, 20'h0);
        asid = 6'd1;
        op_read(mkva(20'd5, 12'h100), 1'b1, mkpa(8'h55, 12'h100));
        asid = 6'd2;
        op_write(mkva(20'd5, 12'h000), mkpa(8'h66, 12'h000));
        op_read(mkva(20'd5, 12'h200), 1'b1, mkpa(8'h66, 12'h200));
        idle();
        n_checks++;
        if (occupancy !== 4'd2) begin n_fail++; $display("FAIL asid_occupancy: got %0d, expected 2", occupancy); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_update();
        test_replace();
        test_back_to_back();
        test_flush();
        test_async_reset();
`ifdef TLB_ASID_EN
        test_asid();
`endif
        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d outstanding reads, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
